// File: rtl/camif_pkg.sv
// Shared Camera_Interface definitions: blink FSM encoding and default LED timing.
package camif_pkg;

    localparam logic [1:0] ST_IDLE_C = 2'd0;
    localparam logic [1:0] ST_ON_C   = 2'd1;
    localparam logic [1:0] ST_OFF_C  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE_C,
        S_ON   = ST_ON_C,
        S_OFF  = ST_OFF_C
    } blink_state_e;

    // 40 ms at 50 MHz
    localparam int ON_CYCLES_DEF  = 2_000_000;
    localparam int OFF_CYCLES_DEF = 2_000_000;

    // Bits needed to count 0..max(on,off)-1; never narrower than one bit.
    function automatic int timer_width(input int on_c, input int off_c);
        int m;
        m = (on_c > off_c) ? on_c : off_c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/led_event_blinker_if.sv
// Event-in / LED-out bundle of the blinker; optional hold input under LED_HOLD_EN.
interface led_event_blinker_if #(
    parameter int Q_W = 4
);
    logic           ev_tick;
    logic           flush;
`ifdef LED_HOLD_EN
    logic           hold;
`endif
    logic           led;
    logic           busy;
    logic [Q_W-1:0] pending;
    logic           overflow;

`ifdef LED_HOLD_EN
    modport master (output ev_tick, flush, hold, input led, busy, pending, overflow);
    modport slave  (input ev_tick, flush, hold, output led, busy, pending, overflow);
`else
    modport master (output ev_tick, flush, input led, busy, pending, overflow);
    modport slave  (input ev_tick, flush, output led, busy, pending, overflow);
`endif

endinterface

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter with synchronous clear and sticky overflow flag.
// Simultaneous inc and dec cancel; inc at full scale holds and sets overflow.
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == {W{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/led_event_blinker.sv
// Turns 1-cycle event ticks into ON/OFF LED blinks, queueing ticks that arrive mid-blink.
// LED_HOLD_EN adds a hold input that forces the LED on and freezes the blink FSM.
module led_event_blinker
    import camif_pkg::*;
#(
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int OFF_CYCLES = OFF_CYCLES_DEF,
    parameter int Q_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    led_event_blinker_if.slave  bus
);

    localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

    blink_state_e   state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           led_q, led_d;
    logic           start;
    logic           frozen;
    logic [Q_W-1:0] pend;
    logic           ovf;
    logic           can_start;

`ifdef LED_HOLD_EN
    assign frozen = bus.hold;
`else
    assign frozen = 1'b0;
`endif

    // A flush in the same cycle wins over launching the next queued blink.
    assign can_start = (pend != '0) && !bus.flush;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start   = 1'b0;
        if (!frozen) begin
            case (state_q)
                S_IDLE: begin
                    if (can_start) begin
                        state_d = S_ON;
                        timer_d = '0;
                        start   = 1'b1;
                    end
                end
                S_ON: begin
                    if (timer_q == ON_LAST) begin
                        state_d = S_OFF;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_OFF: begin
                    if (timer_q == OFF_LAST) begin
                        timer_d = '0;
                        if (can_start) begin
                            state_d = S_ON;
                            start   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end
        led_d = frozen || (state_d == S_ON);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            led_q   <= led_d;
        end
    end

    sat_updown_counter #(
        .W (Q_W)
    ) u_pending (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .inc_i (bus.ev_tick),
        .dec_i (start),
        .cnt_o (pend),
        .ovf_o (ovf)
    );

    assign bus.led      = led_q;
    assign bus.pending  = pend;
    assign bus.overflow = ovf;
    assign bus.busy     = (state_q != S_IDLE) || (pend != '0);

endmodule

// File: tb/tb_led_event_blinker.sv
// Directed plus random ticks/flushes/resets compared each cycle against a blink-schedule model.
module tb_led_event_blinker;

    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int QW   = 2;
    localparam int QMAX = (1 << QW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_event_blinker_if #(.Q_W(QW)) bif ();

    led_event_blinker #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .Q_W        (QW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: a blink occupies ON+OFF cycles counted by "age" from its start.
    int m_pend   = 0;
    int m_ovf    = 0;
    int m_active = 0;
    int m_age    = 0;
    int m_led    = 0;

    task automatic model(input bit t, input bit f, input bit r, input bit h);
        bit eop, start, inc;
        if (r) begin
            m_pend = 0; m_ovf = 0; m_active = 0; m_age = 0; m_led = 0;
            return;
        end
        eop   = (m_active != 0) && (m_age == ON + OFF - 1);
        start = !h && ((m_active == 0) || eop) && (m_pend > 0) && !f;
        if (!h) begin
            if (start) begin
                m_active = 1; m_age = 0;
            end else if (eop) begin
                m_active = 0; m_age = 0;
            end else if (m_active != 0) begin
                m_age = m_age + 1;
            end
        end
        inc = t && !f;
        if (f) begin
            m_pend = 0; m_ovf = 0;
        end else if (inc && !start) begin
            if (m_pend == QMAX) m_ovf = 1;
            else m_pend = m_pend + 1;
        end else if (start && !inc) begin
            m_pend = m_pend - 1;
        end
        m_led = (h || ((m_active != 0) && (m_age < ON))) ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit f, input bit r, input bit h);
        rst_n        = !r;
        bif.ev_tick  = t;
        bif.flush    = f;
`ifdef LED_HOLD_EN
        bif.hold     = h;
`endif
        @(posedge clk);
        model(t, f, r, h);
        #1;
        chk("led",      32'(bif.led),      32'(m_led));
        chk("busy",     32'(bif.busy),     32'((m_active != 0) || (m_pend != 0)));
        chk("pending",  32'(bif.pending),  32'(m_pend));
        chk("overflow", 32'(bif.overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset, then quiet
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        // single tick
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(15);

        // three consecutive ticks
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(30);

        // five ticks saturate the queue, then flush clears overflow
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(40);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // flush + tick together mid-blink
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);

        // reset mid-ON with two pending
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

`ifdef LED_HOLD_EN
        // hold mid-ON with ticks arriving while frozen
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 10; i++) cyc(i == 3 || i == 6, 1'b0, 1'b0, 1'b1);
        idle(40);
`endif

        // random traffic
        for (int i = 0; i < 500; i++) begin
            bit t, f, r, h;
            t = ($urandom_range(99) < 30);
            f = ($urandom_range(99) < 3);
            r = ($urandom_range(199) < 1);
`ifdef LED_HOLD_EN
            h = ($urandom_range(99) < 8);
`else
            h = 1'b0;
`endif
            cyc(t, f, r, h);
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
